// File: rtl/load_store_unit.sv
// Load/store unit: turns one CPU load/store request at a time into
// word-port accesses; sub-word stores use read-modify-write.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only when idle)
//   req_write/funct3/addr    request kind, size/sign and byte address
//   req_wdata                store data (low byte/half for sb/sh)
//   resp_valid/rdata/err     one-cycle completion pulse with result
//   mem_read/write/addr      word-port controls, addr word-aligned
//   mem_wdata/mem_rdata      word-port data (combinational read)
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_WIDTH-3:0] WORD_LIMIT =
    (ADDR_WIDTH-2)'(MEM_WORDS);

  state_t                  state_q, state_d;
  logic                    write_q, write_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             merge_q, merge_d;
  logic [31:0]             rdata_q, rdata_d;

  logic        f3_legal;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic [4:0]  lane_sh;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] store_word;

  // Request screening, evaluated on the raw request in IDLE.
  always_comb begin
    f3_legal = 1'b0;
    if (req_write) begin
      f3_legal = (req_funct3 == 3'b000) ||
                 (req_funct3 == 3'b001) ||
                 (req_funct3 == 3'b010);
    end else begin
      f3_legal = (req_funct3 == 3'b000) ||
                 (req_funct3 == 3'b001) ||
                 (req_funct3 == 3'b010) ||
                 (req_funct3 == 3'b100) ||
                 (req_funct3 == 3'b101);
    end
    misaligned = 1'b0;
    if (req_funct3[1:0] == 2'b01) begin
      misaligned = req_addr[0];
    end else if (req_funct3[1:0] == 2'b10) begin
      misaligned = (req_addr[1:0] != 2'b00);
    end
    out_of_range =
      (req_addr[ADDR_WIDTH-1:2] >= WORD_LIMIT);
    req_err = !f3_legal || misaligned || out_of_range;
  end

  // Lane select and extension of the read word.
  always_comb begin
    lane_sh  = {addr_q[1:0], 3'b000};
    shifted  = mem_rdata >> lane_sh;
    load_val = shifted;
    case (funct3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_val = {24'b0, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_val = {16'b0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // Store word: full word for sw, merged lane for sb/sh.
  always_comb begin
    lane_mask = 32'hFFFF_FFFF;
    lane_data = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        lane_mask = 32'h0000_00FF << lane_sh;
        lane_data = {24'b0, wdata_q[7:0]} << lane_sh;
      end
      2'b01: begin
        lane_mask = 32'h0000_FFFF << lane_sh;
        lane_data = {16'b0, wdata_q[15:0]} << lane_sh;
      end
      default: begin
        lane_mask = 32'hFFFF_FFFF;
        lane_data = wdata_q;
      end
    endcase
    if (funct3_q[1:0] == 2'b10) begin
      store_word = wdata_q;
    end else begin
      store_word = (merge_q & ~lane_mask) |
                   (lane_data & lane_mask);
    end
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = 32'b0;
          if (req_err) begin
            state_d = S_ERR;
          end else if (!req_write) begin
            state_d = S_LOAD;
          end else if (req_funct3[1:0] == 2'b10) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_LOAD: begin
        rdata_d = load_val;
        state_d = S_DONE;
      end
      S_RMW_RD: begin
        merge_d = mem_rdata;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = S_DONE;
      end
      S_DONE, S_ERR: begin
        rdata_d = 32'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      funct3_q <= 3'b0;
      addr_q   <= '0;
      wdata_q  <= 32'b0;
      merge_q  <= 32'b0;
      rdata_q  <= 32'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
    end
  end

  logic mem_busy;

  // Outputs decode from the registered state only; the write strobe
  // is also masked by rst so a reset cycle never commits a store.
  always_comb begin
    mem_busy   = (state_q == S_LOAD) ||
                 (state_q == S_RMW_RD) ||
                 (state_q == S_WRITE);
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_DONE) ||
                 (state_q == S_ERR);
    resp_err   = (state_q == S_ERR);
    resp_rdata = rdata_q;
    mem_read   = (state_q == S_LOAD) ||
                 (state_q == S_RMW_RD);
    mem_write  = (state_q == S_WRITE) && !rst;
    mem_addr   = mem_busy ?
                 {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    mem_wdata  = (state_q == S_WRITE) ?
                 store_word : 32'b0;
  end

  logic unused_write;
  assign unused_write = write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: table vectors, hand-written
// reset/back-to-back sequences and random requests vs a model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(
    .ADDR_WIDTH(32),
    .MEM_WORDS (256)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(
    input  logic        w,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic        err,
    output logic [31:0] rd,
    output int          lat,
    output int          nrd,
    output int          nwr,
    output logic [31:0] wword
  );
    int size;
    int off;
    longint idx;
    logic legal;
    logic [31:0] mask;
    logic [31:0] v;
    off  = int'(a % 4);
    idx  = longint'(a / 4);
    size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    if (w) legal = (f3 <= 2);
    else   legal = (f3 <= 2) || (f3 == 4) || (f3 == 5);
    err   = !legal || (a % size != 0) || (idx >= 256);
    rd    = 32'b0;
    nrd   = 0;
    nwr   = 0;
    wword = 32'b0;
    lat   = 1;
    if (err) return;
    if (!w) begin
      v = ref_mem[idx] >> (8 * off);
      if (size < 4) begin
        mask = (32'h1 << (8 * size)) - 1;
        v = v & mask;
        if (f3 < 4 && v[8*size-1]) v = v | ~mask;
      end
      rd  = v;
      lat = 2;
      nrd = 1;
    end else begin
      if (size == 4) mask = 32'hFFFF_FFFF;
      else mask = ((32'h1 << (8 * size)) - 1) << (8 * off);
      wword = (ref_mem[idx] & ~mask) | ((wd << (8 * off)) & mask);
      lat   = (size == 4) ? 2 : 3;
      nrd   = (size == 4) ? 0 : 1;
      nwr   = 1;
    end
  endfunction

  task automatic run_req(
    input  logic        w,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] got_rd,
    output logic        got_err,
    output int          got_lat
  );
    logic e_err;
    logic [31:0] e_rd, e_ww;
    int e_lat, e_nr, e_nw;
    int nr, nw, g;
    logic [31:0] waddr, wdat;
    logic both, done;
    string tag;
    tag = $sformatf("w=%0d f3=%0d a=%h", w, f3, a);
    model(w, f3, a, wd, e_err, e_rd, e_lat, e_nr, e_nw, e_ww);
    @(negedge clk);
    g = 0;
    while (!req_ready && g < 10) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) check({"idle wait ", tag}, 0, 1);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    got_lat = 0;
    got_rd  = 32'hxxxx_xxxx;
    got_err = 1'bx;
    nr = 0; nw = 0; both = 0; done = 0;
    waddr = 0; wdat = 0;
    for (int c = 1; c <= 8 && !done; c++) begin
      if (c > 1) @(negedge clk);
      if (mem_read) nr++;
      if (mem_write) begin
        nw++;
        waddr = mem_addr;
        wdat  = mem_wdata;
      end
      if (mem_read && mem_write) both = 1;
      if (resp_valid) begin
        got_lat = c;
        got_rd  = resp_rdata;
        got_err = resp_err;
        done    = 1;
      end
    end
    check({"lat ", tag}, got_lat, e_lat);
    check({"err ", tag}, got_err, e_err);
    check({"rdata ", tag}, got_rd, e_rd);
    check({"nread ", tag}, nr, e_nr);
    check({"nwrite ", tag}, nw, e_nw);
    check({"rd&wr ", tag}, both, 0);
    if (e_nw == 1) begin
      check({"waddr ", tag}, waddr, a & ~32'h3);
      check({"wdata ", tag}, wdat, e_ww);
      ref_mem[a / 4] = e_ww;
    end
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          lat;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [31:0] rd;
    logic        e;
    int          l;
    int          k;
    logic [31:0] ra;

    tbl[0]  = '{1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0, 2};
    tbl[1]  = '{1'b0, 3'b010, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0, 2};
    tbl[2]  = '{1'b0, 3'b000, 32'h013, 32'h0, 32'hFFFFFFDE, 1'b0, 2};
    tbl[3]  = '{1'b0, 3'b100, 32'h013, 32'h0, 32'h000000DE, 1'b0, 2};
    tbl[4]  = '{1'b0, 3'b001, 32'h012, 32'h0, 32'hFFFFDEAD, 1'b0, 2};
    tbl[5]  = '{1'b0, 3'b101, 32'h010, 32'h0, 32'h0000BEEF, 1'b0, 2};
    tbl[6]  = '{1'b1, 3'b000, 32'h011, 32'h12345677, 32'h0, 1'b0, 3};
    tbl[7]  = '{1'b0, 3'b010, 32'h010, 32'h0, 32'hDEAD77EF, 1'b0, 2};
    tbl[8]  = '{1'b0, 3'b010, 32'h012, 32'h0, 32'h0, 1'b1, 1};
    tbl[9]  = '{1'b0, 3'b001, 32'h013, 32'h0, 32'h0, 1'b1, 1};
    tbl[10] = '{1'b1, 3'b010, 32'h400, 32'h5, 32'h0, 1'b1, 1};
    tbl[11] = '{1'b1, 3'b100, 32'h020, 32'h5, 32'h0, 1'b1, 1};
    tbl[12] = '{1'b0, 3'b011, 32'h020, 32'h0, 32'h0, 1'b1, 1};
    tbl[13] = '{1'b1, 3'b001, 32'h3FE, 32'h99991234, 32'h0, 1'b0, 3};
    tbl[14] = '{1'b0, 3'b101, 32'h3FE, 32'h0, 32'h00001234, 1'b0, 2};
    tbl[15] = '{1'b0, 3'b000, 32'h3FF, 32'h0, 32'h00000012, 1'b0, 2};

    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b0;
    req_addr   = 32'b0;
    req_wdata  = 32'b0;
    repeat (2) @(negedge clk);
    check("rst ready", req_ready, 1);
    check("rst resp_valid", resp_valid, 0);
    check("rst resp_rdata", resp_rdata, 0);
    check("rst resp_err", resp_err, 0);
    check("rst mem_read", mem_read, 0);
    check("rst mem_write", mem_write, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_req(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd, rd, e, l);
      check($sformatf("tbl%0d rdata", i), rd, tbl[i].rd);
      check($sformatf("tbl%0d err", i), e, tbl[i].err);
      check($sformatf("tbl%0d lat", i), l, tbl[i].lat);
    end

    // sh aborted by reset during its write cycle
    @(negedge clk);
    check("rst-sh idle", req_ready, 1);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b001;
    req_addr   = 32'h10;
    req_wdata  = 32'h0000AAAA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst-sh rmw read", mem_read, 1);
    @(negedge clk);
    check("rst-sh write pre", mem_write, 1);
    rst = 1'b1;
    #1;
    check("rst-sh write gated", mem_write, 0);
    @(negedge clk);
    rst = 1'b0;
    check("rst-sh ready", req_ready, 1);
    check("rst-sh resp", resp_valid, 0);
    check("rst-sh mem_read", mem_read, 0);
    check("rst-sh mem_write", mem_write, 0);
    run_req(1'b0, 3'b010, 32'h10, 32'h0, rd, e, l);
    check("rst-sh old word", rd, 32'hDEAD77EF);

    // three back-to-back lw with req_valid held high
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h20;
    k = 0;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("b2b ready c%0d", i), req_ready, (i % 3 == 0));
      check($sformatf("b2b resp c%0d", i), resp_valid, (i % 3 == 2));
      if (resp_valid) begin
        check($sformatf("b2b rdata %0d", k), resp_rdata, ref_mem[8 + k]);
        k++;
        if (k < 3) req_addr = 32'h20 + 32'(4 * k);
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("b2b count", k, 3);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) ra = $urandom;
      else ra = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1) ra = ra & ~32'h3;
      run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              ra, $urandom, rd, e, l);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
